// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: pipeline memory stage between the execute register and writeback.
// Non-memory ops pass through a registered output slot. Loads and stores are issued one at a
// time over a valid/ready request bus; loads are lane-extracted and sign/zero-extended,
// stores are lane-shifted with byte strobes.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_*                         upstream op (valid/ready), ALU result doubles as address
//   dreq_*                       bus request (valid/ready), held stable until accepted
//   dresp_valid, dresp_data      bus response / write acknowledge
//   out_*                        writeback result (valid/ready), held stable until accepted
//
// Optional feature: define MEM_MISALIGN_CHECK_EN to trap misaligned accesses (no bus request,
// out_misalign=1, out_data=address). Without it, misaligned addresses are force-aligned and
// out_misalign is tied 0.
module mem_stage_lsu #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    input  logic [XLEN-1:0]   in_alu,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [XLEN-1:0]   in_wdata,
    output logic              dreq_valid,
    input  logic              dreq_ready,
    output logic [XLEN-1:0]   dreq_addr,
    output logic              dreq_write,
    output logic [1:0]        dreq_size,
    output logic [STRB_W-1:0] dreq_strobe,
    output logic [XLEN-1:0]   dreq_wdata,
    input  logic              dresp_valid,
    input  logic [XLEN-1:0]   dresp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_we,
    output logic [XLEN-1:0]   out_data,
    output logic              out_misalign
);
    localparam int unsigned OFF_W = $clog2(STRB_W);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e              state_q;
    logic                is_mem;
    logic                bad_size;
    logic [1:0]          lane_size;
    logic [XLEN-1:0]     size_mask;
    logic [XLEN-1:0]     aligned_addr;
    logic [OFF_W-1:0]    off;
    logic [STRB_W-1:0]   strobe;
    logic                accept;

    logic [XLEN-1:0]     req_addr_q;
    logic [XLEN-1:0]     req_wdata_q;
    logic                req_write_q;
    logic [1:0]          req_size_q;
    logic [STRB_W-1:0]   req_strobe_q;
    logic [1:0]          lane_size_q;
    logic                unsigned_q;
    logic [REG_AW-1:0]   rd_q;
    logic                we_q;

    logic                out_valid_q;
    logic [REG_AW-1:0]   out_rd_q;
    logic                out_we_q;
    logic [XLEN-1:0]     out_data_q;

    logic [XLEN-1:0]     shifted;
    logic [XLEN-1:0]     load_val;

`ifdef MEM_MISALIGN_CHECK_EN
    logic                misalign;
    logic                out_misalign_q;
    assign misalign     = bad_size || ((in_alu & size_mask) != '0);
    assign out_misalign = out_misalign_q;
`else
    assign out_misalign = 1'b0;
`endif

    always_comb begin
        is_mem       = in_load | in_store;
        // Doubleword on a 32-bit datapath: treated as a full-width access at an aligned address.
        bad_size     = 32'(in_size) > OFF_W;
        lane_size    = bad_size ? 2'(OFF_W) : in_size;
        size_mask    = (XLEN'(1) << in_size) - XLEN'(1);
        aligned_addr = in_alu & ~size_mask;
        off          = aligned_addr[OFF_W-1:0];
        // Low (1<<size) strobe bits set, then moved up to the byte lane; loads enable all lanes.
        if (in_store) begin
            strobe = ~({STRB_W{1'b1}} << (4'd1 << lane_size)) << off;
        end else begin
            strobe = {STRB_W{1'b1}};
        end
    end

    always_comb begin
        shifted = dresp_data >> {req_addr_q[OFF_W-1:0], 3'b000};
        case (lane_size_q)
            2'd0: begin
                if (unsigned_q) load_val = XLEN'(shifted[7:0]);
                else            load_val = XLEN'($signed(shifted[7:0]));
            end
            2'd1: begin
                if (unsigned_q) load_val = XLEN'(shifted[15:0]);
                else            load_val = XLEN'($signed(shifted[15:0]));
            end
            2'd2: begin
                if (unsigned_q) load_val = XLEN'(shifted[31:0]);
                else            load_val = XLEN'($signed(shifted[31:0]));
            end
            default: load_val = shifted;
        endcase
    end

    assign in_ready    = reset_n && (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign dreq_valid  = (state_q == StReq);
    assign dreq_addr   = req_addr_q;
    assign dreq_write  = req_write_q;
    assign dreq_size   = req_size_q;
    assign dreq_strobe = req_strobe_q;
    assign dreq_wdata  = req_wdata_q;
    assign out_valid   = out_valid_q;
    assign out_rd      = out_rd_q;
    assign out_we      = out_we_q;
    assign out_data    = out_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            req_write_q    <= 1'b0;
            req_size_q     <= '0;
            req_strobe_q   <= '0;
            lane_size_q    <= '0;
            unsigned_q     <= 1'b0;
            rd_q           <= '0;
            we_q           <= 1'b0;
            out_valid_q    <= 1'b0;
            out_rd_q       <= '0;
            out_we_q       <= 1'b0;
            out_data_q     <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            out_misalign_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (out_valid_q && out_ready) out_valid_q <= 1'b0;
                    if (accept) begin
                        if (!is_mem) begin
                            out_valid_q    <= 1'b1;
                            out_rd_q       <= in_rd;
                            out_we_q       <= in_we;
                            out_data_q     <= in_alu;
`ifdef MEM_MISALIGN_CHECK_EN
                            out_misalign_q <= 1'b0;
                        end else if (misalign) begin
                            // Trap straight into the result slot; no bus traffic.
                            out_valid_q    <= 1'b1;
                            out_rd_q       <= in_rd;
                            out_we_q       <= 1'b0;
                            out_data_q     <= in_alu;
                            out_misalign_q <= 1'b1;
                            state_q        <= StDone;
`endif
                        end else begin
                            req_addr_q   <= aligned_addr;
                            req_wdata_q  <= in_wdata << {off, 3'b000};
                            req_write_q  <= in_store;
                            req_size_q   <= in_size;
                            req_strobe_q <= strobe;
                            lane_size_q  <= lane_size;
                            unsigned_q   <= in_unsigned;
                            rd_q         <= in_rd;
                            we_q         <= in_we;
                            state_q      <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (dreq_ready) state_q <= StWait;
                end
                StWait: begin
                    if (dresp_valid) begin
                        // Store acknowledges carry no writeback: we forced low, data zero.
                        out_valid_q    <= 1'b1;
                        out_rd_q       <= rd_q;
                        out_we_q       <= we_q & ~req_write_q;
                        out_data_q     <= req_write_q ? '0 : load_val;
`ifdef MEM_MISALIGN_CHECK_EN
                        out_misalign_q <= 1'b0;
`endif
                        state_q        <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic        in_we = 1'b0;
    logic [63:0] in_alu = '0;
    logic        in_load = 1'b0;
    logic        in_store = 1'b0;
    logic [1:0]  in_size = '0;
    logic        in_unsigned = 1'b0;
    logic [63:0] in_wdata = '0;
    logic        dreq_valid;
    logic        dreq_ready = 1'b0;
    logic [63:0] dreq_addr;
    logic        dreq_write;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_wdata;
    logic        dresp_valid = 1'b0;
    logic [63:0] dresp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_rd;
    logic        out_we;
    logic [63:0] out_data;
    logic        out_misalign;

    mem_stage_lsu dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_we(in_we),
        .in_alu(in_alu), .in_load(in_load), .in_store(in_store), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_wdata(in_wdata),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
        .dreq_write(dreq_write), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
        .dreq_wdata(dreq_wdata), .dresp_valid(dresp_valid), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_we(out_we),
        .out_data(out_data), .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queue of expected results plus one outstanding bus request.
    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [63:0] data;
        logic        mis;
        logic        mem;
    } res_t;
    res_t        outq[$];
    bit          busy = 0, req_pending = 0, waiting = 0;
    logic [63:0] r_addr, r_wdata;
    logic        r_write;
    logic [1:0]  r_size;
    logic [7:0]  r_strb;
    logic [4:0]  p_rd;
    logic        p_we, p_st, p_uns;
    int          p_size, p_off;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_load(logic [63:0] d, int off, int size, bit uns);
        logic [63:0] s;
        logic [63:0] m;
        int bits;
        s = d >> (8 * off);
        bits = 8 << size;
        if (bits == 64) return s;
        m = (64'd1 << bits) - 64'd1;
        s = s & m;
        if (!uns && s[bits-1]) s = s | ~m;
        return s;
    endfunction

    // Called at a negedge after inputs are set; checks outputs, advances model, waits a cycle.
    task automatic step();
        bit          exp_ready;
        logic [63:0] amask;
        logic [63:0] a;
        int          sz;
        int          off;
        #1;
        if (!reset_n) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_out_data", out_data, 64'd0);
            chk("rst_dreq_addr", dreq_addr, 64'd0);
            outq.delete();
            busy = 0;
            req_pending = 0;
            waiting = 0;
        end else begin
            exp_ready = !busy && (outq.size() == 0 || out_ready);
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            chk("out_valid", 64'(out_valid), 64'(outq.size() != 0));
            if (outq.size() != 0) begin
                chk("out_rd", 64'(out_rd), 64'(outq[0].rd));
                chk("out_we", 64'(out_we), 64'(outq[0].we));
                chk("out_data", out_data, outq[0].data);
                chk("out_misalign", 64'(out_misalign), 64'(outq[0].mis));
                if (out_ready) begin
                    if (outq[0].mem) busy = 0;
                    void'(outq.pop_front());
                end
            end
            chk("dreq_valid", 64'(dreq_valid), 64'(req_pending));
            if (req_pending) begin
                chk("dreq_addr", dreq_addr, r_addr);
                chk("dreq_write", 64'(dreq_write), 64'(r_write));
                chk("dreq_size", 64'(dreq_size), 64'(r_size));
                chk("dreq_strobe", 64'(dreq_strobe), 64'(r_strb));
                if (r_write) chk("dreq_wdata", dreq_wdata, r_wdata);
            end
            if (waiting && dresp_valid) begin
                outq.push_back('{p_rd, p_st ? 1'b0 : p_we,
                                 p_st ? 64'd0 : exp_load(dresp_data, p_off, p_size, p_uns),
                                 1'b0, 1'b1});
                waiting = 0;
            end
            if (req_pending && dreq_ready) begin
                req_pending = 0;
                waiting = 1;
            end
            if (in_valid && exp_ready) begin
                if (!(in_load || in_store)) begin
                    outq.push_back('{in_rd, in_we, in_alu, 1'b0, 1'b0});
                end else begin
                    sz = int'(in_size);
                    amask = (64'd1 << sz) - 64'd1;
                    busy = 1;
`ifdef MEM_MISALIGN_CHECK_EN
                    if ((in_alu & amask) != 64'd0) begin
                        outq.push_back('{in_rd, 1'b0, in_alu, 1'b1, 1'b1});
                    end else
`endif
                    begin
                        a = in_alu & ~amask;
                        off = int'(a[2:0]);
                        req_pending = 1;
                        r_addr = a;
                        r_write = in_store;
                        r_size = in_size;
                        r_strb = in_store ? 8'(((1 << (1 << sz)) - 1) << off) : 8'hFF;
                        r_wdata = in_wdata << (8 * off);
                        p_rd = in_rd;
                        p_we = in_we;
                        p_st = in_store;
                        p_uns = in_unsigned;
                        p_size = sz;
                        p_off = off;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_op(bit ld, bit st, logic [63:0] a, logic [1:0] sz, bit uns,
                          logic [63:0] wd, logic [4:0] rd, bit we);
        in_load = ld;
        in_store = st;
        in_alu = a;
        in_size = sz;
        in_unsigned = uns;
        in_wdata = wd;
        in_rd = rd;
        in_we = we;
    endtask

    // Directed memory op with literal expectations for the request and the result.
    task automatic mem_op(string nm, bit st, logic [63:0] addr, logic [1:0] sz, bit uns,
                          logic [63:0] wd, logic [63:0] rdat, int req_hold, int out_hold,
                          logic [63:0] exp_addr, logic [7:0] exp_strb, logic [63:0] exp_wdata,
                          logic [63:0] exp_data);
        set_op(!st, st, addr, sz, uns, wd, 5'd7, 1'b1);
        in_valid = 1;
        out_ready = 1;
        dreq_ready = 0;
        dresp_valid = 0;
        step();
        in_valid = 0;
        for (int i = 0; i <= req_hold; i++) begin
            dreq_ready = (i == req_hold);
            chk({nm, "_dreq_valid"}, 64'(dreq_valid), 64'd1);
            chk({nm, "_dreq_addr"}, dreq_addr, exp_addr);
            chk({nm, "_dreq_write"}, 64'(dreq_write), 64'(st));
            chk({nm, "_dreq_strobe"}, 64'(dreq_strobe), 64'(exp_strb));
            if (st) chk({nm, "_dreq_wdata"}, dreq_wdata, exp_wdata);
            chk({nm, "_in_ready_busy"}, 64'(in_ready), 64'd0);
            step();
        end
        dreq_ready = 0;
        dresp_valid = 1;
        dresp_data = rdat;
        step();
        dresp_valid = 0;
        set_op(0, 0, 64'h99, 2'd0, 0, 64'd0, 5'd9, 1'b1);
        in_valid = (out_hold != 0);
        for (int i = 0; i <= out_hold; i++) begin
            out_ready = (i == out_hold);
            chk({nm, "_out_valid"}, 64'(out_valid), 64'd1);
            chk({nm, "_out_data"}, out_data, exp_data);
            chk({nm, "_out_we"}, 64'(out_we), 64'(!st));
            chk({nm, "_in_ready_done"}, 64'(in_ready), 64'd0);
            step();
        end
        in_valid = 0;
        out_ready = 1;
    endtask

    initial begin
        @(negedge clk);
        step();
        step();
        reset_n = 1;
        out_ready = 1;
        #1 chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);

        // ALU pass-through
        set_op(0, 0, 64'h1234, 2'd0, 0, 64'd0, 5'd5, 1'b1);
        in_valid = 1;
        step();
        in_valid = 0;
        chk("alu_out_valid", 64'(out_valid), 64'd1);
        chk("alu_out_data", out_data, 64'h1234);
        chk("alu_out_rd", 64'(out_rd), 64'd5);
        chk("alu_no_dreq", 64'(dreq_valid), 64'd0);
        step();

        mem_op("lb3", 0, 64'h1003, 2'd0, 0, 0, 64'h8000_0000_0000_0000, 0, 0,
               64'h1003, 8'hFF, 0, 64'd0);
        mem_op("lb7", 0, 64'h1007, 2'd0, 0, 0, 64'h8000_0000_0000_0000, 0, 0,
               64'h1007, 8'hFF, 0, 64'hFFFF_FFFF_FFFF_FF80);
        mem_op("lbu7", 0, 64'h1007, 2'd0, 1, 0, 64'h8000_0000_0000_0000, 0, 3,
               64'h1007, 8'hFF, 0, 64'h80);
        mem_op("sh", 1, 64'h2002, 2'd1, 0, 64'hBEEF, 64'd0, 4, 0,
               64'h2002, 8'h0C, 64'hBEEF_0000, 64'd0);
        mem_op("lw", 0, 64'h100C, 2'd2, 0, 0, 64'h89AB_CDEF_0000_0000, 1, 1,
               64'h100C, 8'hFF, 0, 64'hFFFF_FFFF_89AB_CDEF);
        mem_op("ld", 0, 64'h1008, 2'd3, 0, 0, 64'h0123_4567_89AB_CDEF, 0, 0,
               64'h1008, 8'hFF, 0, 64'h0123_4567_89AB_CDEF);
`ifdef MEM_MISALIGN_CHECK_EN
        set_op(1, 0, 64'h3002, 2'd2, 0, 0, 5'd3, 1'b1);
        in_valid = 1;
        step();
        in_valid = 0;
        chk("mis_no_dreq", 64'(dreq_valid), 64'd0);
        chk("mis_out_valid", 64'(out_valid), 64'd1);
        chk("mis_flag", 64'(out_misalign), 64'd1);
        chk("mis_out_data", out_data, 64'h3002);
        chk("mis_out_we", 64'(out_we), 64'd0);
        step();
`else
        mem_op("lh_align", 0, 64'h2003, 2'd1, 0, 0, 64'h0000_0000_8001_0000, 0, 0,
               64'h2002, 8'hFF, 0, 64'hFFFF_FFFF_FFFF_8001);
`endif

        // Reset while waiting for the response, then a stray response
        set_op(1, 0, 64'h1000, 2'd3, 0, 0, 5'd4, 1'b1);
        in_valid = 1;
        dreq_ready = 1;
        step();
        in_valid = 0;
        step();
        dreq_ready = 0;
        reset_n = 0;
        step();
        reset_n = 1;
        dresp_valid = 1;
        dresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        dresp_valid = 0;
        chk("stray_out_valid", 64'(out_valid), 64'd0);
        chk("stray_dreq_valid", 64'(dreq_valid), 64'd0);
        set_op(0, 0, 64'h55, 2'd0, 0, 0, 5'd6, 1'b1);
        in_valid = 1;
        step();
        in_valid = 0;
        chk("post_rst_data", out_data, 64'h55);
        step();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset_n = !(i >= 2000 && i < 2002);
            set_op(0, 0, {48'd0, 16'($urandom)}, 2'($urandom), 1'($urandom),
                   {$urandom, $urandom}, 5'($urandom), 1'($urandom));
            case ($urandom_range(0, 2))
                0: in_load = 1;
                1: in_store = 1;
                default: ;
            endcase
            in_valid = ($urandom_range(0, 1) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            dreq_ready = ($urandom_range(0, 1) == 0);
            dresp_valid = ($urandom_range(0, 1) == 0);
            dresp_data = {$urandom, $urandom};
            step();
        end
        in_valid = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
